// File: rtl/misc_v_pkg.sv
// Shared decode constants: opcodes, instruction field positions, register file geometry.
package misc_v_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int REG_CNT  = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LW  = 4'h8;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_W   = 8;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 16x16 register file, two combinational reads, one synchronous write, r0 reads zero.
// DECODE_WB_BYPASS_EN: a read of the register being written returns the write data same cycle.
module reg_file
  import misc_v_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b
);

  logic [DATA_W-1:0] r_regs [REG_CNT];
  logic              w_wr;

  assign w_wr = i_wb_en && (i_wb_addr != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] addr);
    logic [DATA_W-1:0] v;
    v = r_regs[addr];
`ifdef DECODE_WB_BYPASS_EN
    if (w_wr && (addr == i_wb_addr)) v = i_wb_data;
`endif
    if (addr == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    o_rd_data_a = rd_port(i_rd_addr_a);
    o_rd_data_b = rd_port(i_rd_addr_b);
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register, field decode, register file read and load-use hazard detect.
// DECODE_WB_BYPASS_EN selects same-cycle write-through on register file reads.
module decode_stage
  import misc_v_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] if_new_pc,
  input  logic [DATA_W-1:0] if_old_pc,
  input  logic [DATA_W-1:0] if_ir,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_old_pc,
  output logic [DATA_W-1:0] id_new_pc,
  output logic [3:0]        id_opcode,
  output logic [REG_AW-1:0] id_rd,
  output logic [REG_AW-1:0] id_rs1,
  output logic [REG_AW-1:0] id_rs2,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic signed [DATA_W-1:0] id_imm,
  output logic              hazard_stall
);

  logic [DATA_W-1:0] r_ir_p1;
  logic [DATA_W-1:0] r_old_pc_p1;
  logic [DATA_W-1:0] r_new_pc_p1;
  logic              r_vld_p1;
  logic              w_rs_match;

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir_p1     <= '0;
      r_old_pc_p1 <= '0;
      r_new_pc_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else if (flush) begin
      r_ir_p1     <= {OP_NOP, {(DATA_W-4){1'b0}}};
      r_old_pc_p1 <= '0;
      r_new_pc_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else if (!stall) begin
      r_ir_p1     <= if_ir;
      r_old_pc_p1 <= if_old_pc;
      r_new_pc_p1 <= if_new_pc;
      r_vld_p1    <= 1'b1;
    end
  end

  assign id_valid  = r_vld_p1;
  assign id_old_pc = r_old_pc_p1;
  assign id_new_pc = r_new_pc_p1;
  assign id_opcode = r_ir_p1[OPC_LSB +: 4];
  assign id_rd     = r_ir_p1[RD_LSB  +: REG_AW];
  assign id_rs1    = r_ir_p1[RS1_LSB +: REG_AW];
  assign id_rs2    = r_ir_p1[RS2_LSB +: REG_AW];
  assign id_imm    = sext_imm(r_ir_p1[IMM_W-1:0]);

  reg_file u_reg_file (
    .clk         (clk),
    .reset       (reset),
    .i_wb_en     (wb_en),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_rd_addr_a (id_rs1),
    .i_rd_addr_b (id_rs2),
    .o_rd_data_a (id_rs1_data),
    .o_rd_data_b (id_rs2_data)
  );

  // A bubble never stalls, and a load into r0 cannot create a dependency.
  assign w_rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign hazard_stall = r_vld_p1 && ex_mem_read && (ex_rd != '0) && w_rs_match;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a behavioural IF/ID + register file model checked every cycle.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_new_pc, if_old_pc, if_ir;
  logic        stall, flush, wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_mem_read;
  logic [3:0]  ex_rd;
  logic        id_valid;
  logic [15:0] id_old_pc, id_new_pc;
  logic [3:0]  id_opcode, id_rd, id_rs1, id_rs2;
  logic [15:0] id_rs1_data, id_rs2_data;
  logic signed [15:0] id_imm;
  logic        hazard_stall;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_new_pc(if_new_pc), .if_old_pc(if_old_pc), .if_ir(if_ir),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_valid(id_valid), .id_old_pc(id_old_pc),
    .id_new_pc(id_new_pc), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural IF/ID state and register array.
  logic [15:0] m_ir, m_old, m_new;
  logic        m_valid;
  logic [15:0] m_rf [16];
  bit          m_init = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_ir = 0; m_old = 0; m_new = 0; m_valid = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
      m_init = 1;
    end else begin
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
      if (flush) begin
        m_ir = 0; m_old = 0; m_new = 0; m_valid = 0;
      end else if (!stall) begin
        m_ir = if_ir; m_old = if_old_pc; m_new = if_new_pc; m_valid = 1;
      end
    end
  end

  function automatic logic [15:0] m_read(input int idx);
    if (idx == 0) return 16'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      int rs1, rs2;
      int imm;
      logic hz;
      rs1 = int'(m_ir / 16) % 16;
      rs2 = int'(m_ir) % 16;
      imm = int'(m_ir) % 256;
      if (imm >= 128) imm = imm - 256;
      hz = m_valid && ex_mem_read && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
      check("m_valid",  {15'h0, id_valid}, {15'h0, m_valid});
      check("m_oldpc",  id_old_pc, m_old);
      check("m_newpc",  id_new_pc, m_new);
      check("m_opcode", {12'h0, id_opcode}, 16'(int'(m_ir) / 4096));
      check("m_rd",     {12'h0, id_rd}, 16'((int'(m_ir) / 256) % 16));
      check("m_rs1",    {12'h0, id_rs1}, 16'(rs1));
      check("m_rs2",    {12'h0, id_rs2}, 16'(rs2));
      check("m_imm",    id_imm, 16'(imm));
      check("m_rs1d",   id_rs1_data, m_read(rs1));
      check("m_rs2d",   id_rs2_data, m_read(rs2));
      check("m_hazard", {15'h0, hazard_stall}, {15'h0, hz});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 0; if_ir = 16'h1234; if_old_pc = 16'h0002; if_new_pc = 16'h0004;
    stall = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_mem_read = 0; ex_rd = 0;
    step(); step();
    check("rst_valid",  {15'h0, id_valid}, 16'h0);
    check("rst_opcode", {12'h0, id_opcode}, 16'h0);
    check("rst_imm",    id_imm, 16'h0);
    check("rst_oldpc",  id_old_pc, 16'h0);
    check("rst_rs1d",   id_rs1_data, 16'h0);
    check("rst_hazard", {15'h0, hazard_stall}, 16'h0);

    reset = 1; if_ir = 16'h3A5C; if_old_pc = 16'h0010; if_new_pc = 16'h0012;
    step();
    check("pipe_opcode", {12'h0, id_opcode}, 16'h3);
    check("pipe_rd",     {12'h0, id_rd}, 16'hA);
    check("pipe_rs1",    {12'h0, id_rs1}, 16'h5);
    check("pipe_rs2",    {12'h0, id_rs2}, 16'hC);
    check("pipe_imm",    id_imm, 16'h005C);
    check("pipe_valid",  {15'h0, id_valid}, 16'h1);
    check("pipe_oldpc",  id_old_pc, 16'h0010);
    check("pipe_newpc",  id_new_pc, 16'h0012);

    stall = 1; if_ir = 16'hFFFF; if_old_pc = 16'h0020;
    step();
    check("stall_opcode", {12'h0, id_opcode}, 16'h3);
    check("stall_oldpc",  id_old_pc, 16'h0010);
    flush = 1;
    step();
    check("flush_valid",  {15'h0, id_valid}, 16'h0);
    check("flush_opcode", {12'h0, id_opcode}, 16'h0);
    check("flush_newpc",  id_new_pc, 16'h0);

    stall = 0; flush = 0; if_ir = 16'h1050; if_old_pc = 16'h0030; if_new_pc = 16'h0032;
    wb_en = 1; wb_addr = 5; wb_data = 16'hBEEF;
    step();
    check("rf_read5", id_rs1_data, 16'hBEEF);
    wb_en = 0; if_ir = 16'h1060;
    step();
    wb_en = 1; wb_addr = 6; wb_data = 16'h1234; #1;
`ifdef DECODE_WB_BYPASS_EN
    check("rf_same_cyc", id_rs1_data, 16'h1234);
`else
    check("rf_same_cyc", id_rs1_data, 16'h0000);
`endif
    step();
    wb_en = 0; #1;
    check("rf_next_cyc", id_rs1_data, 16'h1234);
    wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; if_ir = 16'h1000;
    step();
    wb_en = 0; #1;
    check("rf_r0", id_rs1_data, 16'h0);

    if_ir = 16'h1207;
    step();
    ex_mem_read = 1; ex_rd = 7; #1;
    check("hz_rs2", {15'h0, hazard_stall}, 16'h1);
    ex_rd = 0; #1;
    check("hz_rd0", {15'h0, hazard_stall}, 16'h0);
    ex_rd = 7; ex_mem_read = 0; #1;
    check("hz_nold", {15'h0, hazard_stall}, 16'h0);
    ex_mem_read = 1; if_ir = 16'h1070;
    step();
    check("hz_rs1", {15'h0, hazard_stall}, 16'h1);
    flush = 1; if_ir = 16'h1777;
    step();
    check("hz_flush", {15'h0, hazard_stall}, 16'h0);
    flush = 0; ex_mem_read = 0; ex_rd = 0;

    if_ir = 16'h2180;
    step();
    check("sext_imm", id_imm, 16'hFF80);

    reset = 0; wb_en = 1; wb_addr = 3; wb_data = 16'hAAAA; if_ir = 16'h1030;
    step();
    reset = 1; wb_en = 0;
    step();
    check("rst_wr_drop", id_rs1_data, 16'h0);

    for (int i = 0; i < 40; i++) begin
      if_ir = 16'($urandom); if_old_pc = 16'($urandom); if_new_pc = if_old_pc + 16'd2;
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 5) == 0);
      wb_en = $urandom_range(0, 1); wb_addr = 4'($urandom); wb_data = 16'($urandom);
      ex_mem_read = $urandom_range(0, 1); ex_rd = 4'($urandom);
      step();
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
